// File: rtl/alu_pkg.sv
// Shared ALU select codes, opcodes, FSM encoding and instruction field layout
// for the issue controller and its register file.
package alu_pkg;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;

  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd1;
  localparam logic [7:0] OP_ADD   = 8'd2;
  localparam logic [7:0] OP_SUB   = 8'd3;
  localparam logic [7:0] OP_AND   = 8'd4;
  localparam logic [7:0] OP_OR    = 8'd5;
  localparam logic [7:0] OP_J     = 8'd6;
  localparam logic [7:0] OP_BEQ   = 8'd7;
  localparam logic [7:0] OP_MULT  = 8'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  localparam int OPC_LSB = 24;
  localparam int RD_LSB  = 16;
  localparam int RS1_LSB = 8;
  localparam int RS2_LSB = 0;
  localparam int FLD_W   = 8;

  // A register field is only legal when it names one of the 8 registers.
  function automatic logic fld_bad(input logic [7:0] f);
    return |f[7:3];
  endfunction

endpackage

// File: rtl/reg_file8x8.sv
// 8x8 register file: two async read ports plus a debug port, sync write, async clear.
// Reads are combinational; a write is visible after the edge that performs it.
module reg_file8x8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [2:0] waddr,
  input  logic [7:0] wdata,
  input  logic [2:0] raddr1,
  output logic [7:0] rdata1,
  input  logic [2:0] raddr2,
  output logic [7:0] rdata2,
  input  logic [2:0] dbg_addr,
  output logic [7:0] dbg_data
);

  logic [7:0] mem [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1   = mem[raddr1];
  assign rdata2   = mem[raddr2];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: decodes an instruction, drives the external ALU, waits a fixed settle time, writes back.
// DONE N+1 cycles after accept (illegal: 1); INSTR_READY only in IDLE, so one instruction per N+2 cycles.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned ALU_WAIT = 2,
  parameter int unsigned MUL_WAIT = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTR,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  output logic [7:0]  ALU_DATA1,
  output logic [7:0]  ALU_DATA2,
  output logic [2:0]  ALU_SELECT,
  input  logic [7:0]  ALU_RESULT,
  input  logic        ALU_ZERO,
  output logic        DONE,
  output logic        ERR,
  output logic        BRANCH_TAKEN,
  output logic [7:0]  BRANCH_OFFSET,
  input  logic [2:0]  DBG_ADDR,
  output logic [7:0]  DBG_DATA
);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic [7:0] opc, rd_f, rs1_f, rs2_f;
  logic [7:0] rs1_val, rs2_val, rs2_neg;
  logic [2:0] dec_sel;
  logic [7:0] dec_d1, dec_d2;
  logic       dec_wr, dec_beq, dec_jmp, dec_bad, dec_mul;
  logic       accept;
  logic       err_q, wr_q, beq_q, jmp_q, taken_q;
  logic [2:0] rd_q;
  logic [7:0] off_q, res_q;
  logic       rf_we;

  assign opc   = INSTR[OPC_LSB +: FLD_W];
  assign rd_f  = INSTR[RD_LSB  +: FLD_W];
  assign rs1_f = INSTR[RS1_LSB +: FLD_W];
  assign rs2_f = INSTR[RS2_LSB +: FLD_W];

  reg_file8x8 u_rf (
    .clk      (CLK),
    .rst_n    (RESET),
    .we       (rf_we),
    .waddr    (rd_q),
    .wdata    (res_q),
    .raddr1   (rs1_f[2:0]),
    .rdata1   (rs1_val),
    .raddr2   (rs2_f[2:0]),
    .rdata2   (rs2_val),
    .dbg_addr (DBG_ADDR),
    .dbg_data (DBG_DATA)
  );

  // The ALU only adds, so subtraction is fed the two's complement of rs2.
  assign rs2_neg = ~rs2_val + 8'd1;

  // Forward ops present their value on operand 1; operand 2 is left at 0.
  always_comb begin
    dec_sel = ALU_FWD;
    dec_d1  = '0;
    dec_d2  = '0;
    dec_wr  = 1'b0;
    dec_beq = 1'b0;
    dec_jmp = 1'b0;
    dec_mul = 1'b0;
    dec_bad = 1'b0;
    unique case (opc)
      OP_LOADI: begin
        dec_d1 = rs2_f; dec_wr = 1'b1; dec_bad = fld_bad(rd_f);
      end
      OP_MOV: begin
        dec_d1 = rs2_val; dec_wr = 1'b1; dec_bad = fld_bad(rd_f) | fld_bad(rs2_f);
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MULT: begin
        dec_d1  = rs1_val;
        dec_d2  = (opc == OP_SUB) ? rs2_neg : rs2_val;
        dec_sel = (opc == OP_AND)  ? ALU_AND :
                  (opc == OP_OR)   ? ALU_OR  :
                  (opc == OP_MULT) ? ALU_MUL : ALU_ADD;
        dec_mul = (opc == OP_MULT);
        dec_wr  = 1'b1;
        dec_bad = fld_bad(rd_f) | fld_bad(rs1_f) | fld_bad(rs2_f);
      end
      OP_J: dec_jmp = 1'b1;
      OP_BEQ: begin
        dec_sel = ALU_ADD; dec_d1 = rs1_val; dec_d2 = rs2_neg; dec_beq = 1'b1;
        dec_bad = fld_bad(rs1_f) | fld_bad(rs2_f);
      end
      default: dec_bad = 1'b1;
    endcase
  end

  assign accept = (state == ST_IDLE) && INSTR_VALID;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Counter is loaded with N >= 1; WAIT lasts exactly N cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (INSTR_VALID) state_nxt = dec_bad ? ST_WB : ST_WAIT;
      ST_WAIT: if (cnt == 8'd1) state_nxt = ST_WB;
      ST_WB:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    INSTR_READY   = (state == ST_IDLE);
    DONE          = (state == ST_WB);
    ERR           = (state == ST_WB) && err_q;
    BRANCH_TAKEN  = (state == ST_WB) && taken_q;
    BRANCH_OFFSET = (state == ST_WB) ? off_q : 8'd0;
    rf_we         = (state == ST_WB) && wr_q;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt        <= '0;
      ALU_DATA1  <= '0;
      ALU_DATA2  <= '0;
      ALU_SELECT <= ALU_FWD;
      err_q      <= 1'b0;
      wr_q       <= 1'b0;
      beq_q      <= 1'b0;
      jmp_q      <= 1'b0;
      taken_q    <= 1'b0;
      rd_q       <= '0;
      off_q      <= '0;
      res_q      <= '0;
    end else if (accept) begin
      err_q   <= dec_bad;
      wr_q    <= dec_wr & ~dec_bad;
      beq_q   <= dec_beq & ~dec_bad;
      jmp_q   <= dec_jmp & ~dec_bad;
      taken_q <= 1'b0;
      rd_q    <= rd_f[2:0];
      off_q   <= ((dec_beq | dec_jmp) & ~dec_bad) ? rd_f : 8'd0;
      if (!dec_bad) begin
        ALU_DATA1  <= dec_d1;
        ALU_DATA2  <= dec_d2;
        ALU_SELECT <= dec_sel;
        cnt        <= dec_mul ? 8'(MUL_WAIT) : 8'(ALU_WAIT);
      end
    end else if (state == ST_WAIT) begin
      cnt <= cnt - 8'd1;
      if (cnt == 8'd1) begin
        res_q   <= ALU_RESULT;
        taken_q <= jmp_q | (beq_q & ALU_ZERO);
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU; completions are checked
// by a scoreboard monitor, register contents through the debug port.
module tb_alu_issue_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTR;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [7:0]  ALU_DATA1, ALU_DATA2;
  logic [2:0]  ALU_SELECT;
  logic [7:0]  ALU_RESULT;
  logic        ALU_ZERO;
  logic        DONE, ERR, BRANCH_TAKEN;
  logic [7:0]  BRANCH_OFFSET;
  logic [2:0]  DBG_ADDR;
  logic [7:0]  DBG_DATA;

  alu_issue_ctrl #(.ALU_WAIT(2), .MUL_WAIT(4)) dut (
    .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2),
    .ALU_SELECT(ALU_SELECT), .ALU_RESULT(ALU_RESULT), .ALU_ZERO(ALU_ZERO),
    .DONE(DONE), .ERR(ERR), .BRANCH_TAKEN(BRANCH_TAKEN),
    .BRANCH_OFFSET(BRANCH_OFFSET), .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA)
  );

  always #5 CLK = ~CLK;

  // Behavioural ALU: forward passes operand 1.
  logic [15:0] prod;
  always_comb begin
    prod = 16'(ALU_DATA1) * 16'(ALU_DATA2);
    case (ALU_SELECT)
      3'b000:  ALU_RESULT = ALU_DATA1;
      3'b001:  ALU_RESULT = ALU_DATA1 + ALU_DATA2;
      3'b010:  ALU_RESULT = ALU_DATA1 & ALU_DATA2;
      3'b011:  ALU_RESULT = ALU_DATA1 | ALU_DATA2;
      3'b100:  ALU_RESULT = prod[7:0];
      default: ALU_RESULT = 8'd0;
    endcase
    ALU_ZERO = (ALU_RESULT == 8'd0);
  end

  typedef struct {
    int         cyc;
    logic       err;
    logic       taken;
    logic [7:0] off;
  } exp_t;

  exp_t sbq[$];
  int   edge_cnt = 0;
  int   nchk = 0;
  int   nerr = 0;

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // The cycle following edge e is cycle e+1.
  always @(negedge CLK) begin
    if (DONE) begin
      if (sbq.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_done: DONE=1 in cycle %0d, expected no completion", edge_cnt + 1);
      end else begin
        exp_t x;
        x = sbq.pop_front();
        chk("done_cycle", edge_cnt + 1, x.cyc);
        chk("err", int'(ERR), int'(x.err));
        chk("branch_taken", int'(BRANCH_TAKEN), int'(x.taken));
        chk("branch_offset", int'(BRANCH_OFFSET), int'(x.off));
      end
    end
  end

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] a,
                                     input logic [7:0] b, input logic [7:0] c);
    return {op, a, b, c};
  endfunction

  task automatic push_exp(input int cyc, input logic err, input logic tk, input logic [7:0] off);
    exp_t x;
    x.cyc = cyc; x.err = err; x.taken = tk; x.off = off;
    sbq.push_back(x);
  endtask

  task automatic wait_ready();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK);
      if (INSTR_READY) seen = 1'b1;
    end
    if (!seen) begin
      nchk++;
      nerr++;
      $display("FAIL ready_timeout: INSTR_READY=0 for 100 cycles, expected 1");
    end
  endtask

  // n = settle cycles (0 for illegal); DONE expected in cycle accept_edge + n + 1.
  task automatic issue(input logic [31:0] w, input int n, input logic err,
                       input logic tk, input logic [7:0] off);
    wait_ready();
    INSTR = w;
    INSTR_VALID = 1'b1;
    push_exp(edge_cnt + 1 + n + 1, err, tk, off);
    @(posedge CLK);
    #1;
    INSTR_VALID = 1'b0;
  endtask

  task automatic check_reg(input logic [2:0] idx, input logic [7:0] val, input string nm);
    wait_ready();
    DBG_ADDR = idx;
    #1;
    chk(nm, int'(DBG_DATA), int'(val));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] imm;
    RESET = 1'b0;
    INSTR = '0;
    INSTR_VALID = 1'b0;
    DBG_ADDR = 3'd0;
    repeat (2) @(negedge CLK);
    chk("rst_done", int'(DONE), 0);
    chk("rst_select", int'(ALU_SELECT), 0);
    chk("rst_data1", int'(ALU_DATA1), 0);
    chk("rst_r0", int'(DBG_DATA), 0);
    RESET = 1'b1;
    @(negedge CLK);
    chk("rst_ready", int'(INSTR_READY), 1);

    // loadi / add
    issue(mk(8'd0, 8'd1, 8'd0, 8'd5), 2, 1'b0, 1'b0, 8'h00);
    issue(mk(8'd0, 8'd2, 8'd0, 8'd3), 2, 1'b0, 1'b0, 8'h00);
    issue(mk(8'd2, 8'd3, 8'd1, 8'd2), 2, 1'b0, 1'b0, 8'h00);
    check_reg(3'd3, 8'h08, "add_r3");

    // sub and branches
    issue(mk(8'd3, 8'd4, 8'd1, 8'd2), 2, 1'b0, 1'b0, 8'h00);
    check_reg(3'd4, 8'h02, "sub_r4");
    issue(mk(8'd7, 8'hFC, 8'd1, 8'd1), 2, 1'b0, 1'b1, 8'hFC);
    issue(mk(8'd7, 8'h10, 8'd1, 8'd2), 2, 1'b0, 1'b0, 8'h10);
    issue(mk(8'd6, 8'h05, 8'd0, 8'd0), 2, 1'b0, 1'b1, 8'h05);

    // mult: select must read 100 for every WAIT cycle
    issue(mk(8'd0, 8'd1, 8'd0, 8'h10), 2, 1'b0, 1'b0, 8'h00);
    issue(mk(8'd0, 8'd2, 8'd0, 8'h11), 2, 1'b0, 1'b0, 8'h00);
    issue(mk(8'd8, 8'd5, 8'd1, 8'd2), 4, 1'b0, 1'b0, 8'h00);
    chk("mul_sel_wait0", int'(ALU_SELECT), 4);
    for (int i = 1; i < 4; i++) begin
      @(negedge CLK);
      chk("mul_sel_wait", int'(ALU_SELECT), 4);
    end
    check_reg(3'd5, 8'h10, "mult_r5");

    // illegal opcode and illegal rd field
    issue(mk(8'h20, 8'd0, 8'd0, 8'd0), 0, 1'b1, 1'b0, 8'h00);
    issue(mk(8'd2, 8'h09, 8'd1, 8'd2), 0, 1'b1, 1'b0, 8'h00);
    check_reg(3'd1, 8'h10, "illegal_r1");
    check_reg(3'd2, 8'h11, "illegal_r2");
    check_reg(3'd3, 8'h08, "illegal_r3");
    check_reg(3'd0, 8'h00, "illegal_r0");

    // INSTR_VALID held high: only words seen in IDLE (every 4th) execute
    wait_ready();
    for (int i = 0; i < 10; i++) begin
      imm = 8'h30 + 8'(i);
      INSTR = mk(8'd0, 8'd6, 8'd0, imm);
      INSTR_VALID = 1'b1;
      if (i % 4 == 0) push_exp(edge_cnt + 1 + 3, 1'b0, 1'b0, 8'h00);
      @(negedge CLK);
    end
    INSTR_VALID = 1'b0;
    check_reg(3'd6, 8'h38, "stream_r6");

    // back-to-back read-after-write, then and/or/mov
    issue(mk(8'd0, 8'd1, 8'd0, 8'd7), 2, 1'b0, 1'b0, 8'h00);
    issue(mk(8'd2, 8'd1, 8'd1, 8'd1), 2, 1'b0, 1'b0, 8'h00);
    check_reg(3'd1, 8'h0E, "raw_r1");
    issue(mk(8'd5, 8'd7, 8'd1, 8'd2), 2, 1'b0, 1'b0, 8'h00);
    issue(mk(8'd4, 8'd6, 8'd1, 8'd2), 2, 1'b0, 1'b0, 8'h00);
    issue(mk(8'd1, 8'd0, 8'd0, 8'd2), 2, 1'b0, 1'b0, 8'h00);
    check_reg(3'd7, 8'h1F, "or_r7");
    check_reg(3'd6, 8'h00, "and_r6");
    check_reg(3'd0, 8'h11, "mov_r0");

    // reset two cycles into a mult: no completion, everything cleared
    wait_ready();
    INSTR = mk(8'd8, 8'd5, 8'd1, 8'd2);
    INSTR_VALID = 1'b1;
    @(posedge CLK);
    #1;
    INSTR_VALID = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      DBG_ADDR = 3'(i);
      #1;
      chk("midrst_reg", int'(DBG_DATA), 0);
    end
    chk("midrst_done", int'(DONE), 0);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("postrst_ready", int'(INSTR_READY), 1);
    chk("postrst_select", int'(ALU_SELECT), 0);
    chk("postrst_data2", int'(ALU_DATA2), 0);
    repeat (8) @(negedge CLK);
    DBG_ADDR = 3'd5;
    #1;
    chk("postrst_r5", int'(DBG_DATA), 0);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
